// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the M-stage branch resolve unit.
//   - RS_IDLE / RS_HOLD   : redirect FSM encodings
//   - pred_state_e        : 2-bit saturating predictor states (shared with the local predictor)
//   - rec_e_t / rec_m_t   : E-stage and M-stage branch records
//   - corrected_pc()      : fetch PC to use after a mispredict
package branch_resolve_unit_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_HOLD = 1'b1
  } rs_state_e;

  typedef enum logic [1:0] {
    PS_STRONG_NT = 2'b00,
    PS_WEAK_NT   = 2'b01,
    PS_WEAK_T    = 2'b10,
    PS_STRONG_T  = 2'b11
  } pred_state_e;

  typedef struct packed {
    logic        valid;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
  } rec_e_t;

  typedef struct packed {
    logic        valid;
    logic        pred;
    logic        actual;
    logic [31:0] pc;
    logic [31:0] target;
  } rec_m_t;

  // Taken branches resume at the target, not-taken at the fall-through (wraps at 2^32).
  function automatic logic [31:0] corrected_pc(input rec_m_t r);
    return r.actual ? r.target : (r.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Redirect handshake and predictor update bus of the branch resolve unit.
//   master (resolve unit): drives redirect_valid/redirect_pc and the upd_* strobe,
//                          samples redirect_ready from fetch.
//   slave  (fetch/predictor side): the mirror image.
interface branch_resolve_unit_if;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        upd_branchM;
  logic        upd_takeM;
  logic [31:0] upd_pcM;

  modport master (
    output redirect_valid, redirect_pc, upd_branchM, upd_takeM, upd_pcM,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid, redirect_pc, upd_branchM, upd_takeM, upd_pcM,
    output redirect_ready
  );
endinterface

// File: rtl/branch_resolve_unit_flopenrc.sv
// flopenrc: stage register with synchronous reset, synchronous clear and enable.
//   clk, rst : clock, synchronous active-high reset
//   i_en     : load i_d when high
//   i_clr    : synchronous clear, takes priority over i_en
//   i_d/o_q  : data in / registered data out
module flopenrc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks D-stage predictions once the branch reaches M,
// requests a fetch redirect (and pipeline flush) on a mispredict, drives the
// predictor update strobe and keeps saturating branch/mispredict counters.
//   clk, rst                 : clock, synchronous active-high reset
//   i_stallE / i_stallM      : hold E / M stage records
//   i_branchD, i_pred_takeD  : D-stage branch flag and predicted direction
//   i_pcD, i_targetD         : branch PC and taken target
//   i_actual_takeE           : resolved direction, joins the record entering M
//   bus (master)             : redirect handshake + predictor update port
//   o_flushD/E/M             : kill younger instructions (== redirect_valid)
//   o_correctM               : M-stage prediction was right (1 with no branch)
//   o_branch_cnt/o_mispred_cnt : saturating performance counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stallE,
  input  logic                 i_stallM,
  input  logic                 i_branchD,
  input  logic                 i_pred_takeD,
  input  logic [31:0]          i_pcD,
  input  logic [31:0]          i_targetD,
  input  logic                 i_actual_takeE,
  branch_resolve_unit_if.master bus,
  output logic                 o_flushD,
  output logic                 o_flushE,
  output logic                 o_flushM,
  output logic                 o_correctM,
  output logic [CNT_W-1:0]     o_branch_cnt,
  output logic [CNT_W-1:0]     o_mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rec_e_t           w_recD;
  rec_e_t           w_recE;
  rec_m_t           w_recE2M;
  rec_m_t           w_recM;
  logic             w_flush;
  logic             w_mispredM;
  logic             w_updM;
  logic [31:0]      w_fix_pc;

  rs_state_e        r_state;
  logic [31:0]      r_hold_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  assign w_recD = '{valid: i_branchD, pred: i_pred_takeD, pc: i_pcD, target: i_targetD};

  flopenrc #(.WIDTH($bits(rec_e_t))) u_rec_e (
    .clk   (clk),
    .rst   (rst),
    .i_en  (~i_stallE),
    .i_clr (w_flush),
    .i_d   (w_recD),
    .o_q   (w_recE)
  );

  assign w_recE2M = '{valid:  w_recE.valid,
                      pred:   w_recE.pred,
                      actual: i_actual_takeE,
                      pc:     w_recE.pc,
                      target: w_recE.target};

  flopenrc #(.WIDTH($bits(rec_m_t))) u_rec_m (
    .clk   (clk),
    .rst   (rst),
    .i_en  (~i_stallM),
    .i_clr (w_flush),
    .i_d   (w_recE2M),
    .o_q   (w_recM)
  );

  assign w_mispredM = w_recM.valid & (w_recM.actual != w_recM.pred);
  assign w_fix_pc   = corrected_pc(w_recM);
  // Update only on the cycle the branch leaves M, so a stalled branch counts once.
  assign w_updM     = w_recM.valid & ~i_stallM;

  // In HOLD the latched PC is replayed; anything reaching M meanwhile is flushed.
  assign bus.redirect_valid = (r_state == RS_HOLD) | w_mispredM;
  assign bus.redirect_pc    = (r_state == RS_HOLD) ? r_hold_pc : w_fix_pc;
  assign bus.upd_branchM    = w_updM;
  assign bus.upd_pcM        = w_recM.pc;
  assign bus.upd_takeM      = w_recM.actual;

  assign w_flush    = bus.redirect_valid;
  assign o_flushD   = w_flush;
  assign o_flushE   = w_flush;
  assign o_flushM   = w_flush;
  assign o_correctM = ~w_mispredM;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RS_IDLE;
      r_hold_pc <= '0;
    end else begin
      case (r_state)
        RS_IDLE: begin
          if (w_mispredM && !bus.redirect_ready) begin
            r_state   <= RS_HOLD;
            r_hold_pc <= w_fix_pc;
          end
        end
        RS_HOLD: begin
          if (bus.redirect_ready) begin
            r_state <= RS_IDLE;
          end
        end
        default: r_state <= RS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_updM) begin
      if (r_branch_cnt != CNT_MAX) begin
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      end
      if (w_mispredM && (r_mispred_cnt != CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      end
    end
  end

  assign o_branch_cnt  = r_branch_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule
